// File: rtl/tri_vertex_unpacker.sv
// tri_vertex_unpacker: buffers whole triangles in a small FIFO and replays them one vertex per handshake,
// then pulses obj_done_out once an announced object has fully drained.
module tri_vertex_unpacker #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [3:0][31:0]      v1_in,
  input  logic [3:0][31:0]      v2_in,
  input  logic [3:0][31:0]      v3_in,
  input  logic                  valid_in,
  input  logic                  obj_done_in,
  output logic                  ready_out,
  output logic [3:0][31:0]      vert_out,
  output logic [1:0]            vert_idx_out,
  output logic                  tri_last_out,
  output logic                  vert_valid_out,
  input  logic                  vert_ready_in,
  output logic                  obj_done_out,
  output logic [CNT_W-1:0]      tri_count_out
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2;
  logic [2:0][3:0][31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d, idx_q, idx_d;
  logic pend_q, pend_d, push, pop;
  logic [CNT_W-1:0] tri_q;
  // ready comes from the registered occupancy only, so a same-cycle pop never frees a full FIFO
  assign ready_out = !rst_in && (cnt_q < (AW+1)'(DEPTH));
  assign push = valid_in && ready_out;
  assign pop = (state_q == EMIT) && vert_ready_in && (idx_q == 2'd2);
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pend_d = pend_q | obj_done_in;
    if (state_q == IDLE) begin
      state_d = (cnt_q != '0) ? EMIT : pend_q ? DONE : IDLE;
      idx_d = 2'd0;
    end else if (state_q == EMIT) begin
      idx_d = !vert_ready_in ? idx_q : (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      state_d = !pop ? EMIT : (cnt_d != '0) ? EMIT : pend_q ? DONE : IDLE;
    end else begin
      state_d = IDLE;
      pend_d = obj_done_in;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      idx_q <= 2'd0;
      pend_q <= 1'b0;
      tri_q <= '0;
    end else begin
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
      state_q <= state_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      tri_q <= (push && !(&tri_q)) ? tri_q + CNT_W'(1) : tri_q;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_q] <= {v3_in, v2_in, v1_in};
  end
  assign vert_valid_out = (state_q == EMIT);
  assign vert_out = vert_valid_out ? mem_q[rd_q][idx_q] : '0;
  assign vert_idx_out = idx_q;
  assign tri_last_out = vert_valid_out && (idx_q == 2'd2);
  assign obj_done_out = (state_q == DONE);
  assign tri_count_out = tri_q;
endmodule

// File: tb/tb_tri_vertex_unpacker.sv
// tb_tri_vertex_unpacker: scoreboard bench for tri_vertex_unpacker; expected vertices are queued when a
// triangle is accepted and compared in order at each output handshake.
module tb_tri_vertex_unpacker;
  typedef logic [130:0] obs_t;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [3:0][31:0] v1_in = '0, v2_in = '0, v3_in = '0;
  logic valid_in = 1'b0, obj_done_in = 1'b0, vert_ready_in = 1'b0;
  logic ready_out, tri_last_out, vert_valid_out, obj_done_out;
  logic [3:0][31:0] vert_out;
  logic [1:0] vert_idx_out;
  logic [15:0] tri_count_out;
  obs_t sb[$];
  obs_t held, cur;
  int n_cmp = 0, n_bad = 0, hs_cnt = 0, cyc = 0, done_pulses = 0, done_cycles = 0, done_hs = 0;
  int hs_cyc[512];
  bit rnd_mode = 1'b0, rdy_fix = 1'b1, saw_full = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;

  tri_vertex_unpacker #(.DEPTH(2), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
    .valid_in(valid_in), .obj_done_in(obj_done_in), .ready_out(ready_out), .vert_out(vert_out),
    .vert_idx_out(vert_idx_out), .tri_last_out(tri_last_out), .vert_valid_out(vert_valid_out),
    .vert_ready_in(vert_ready_in), .obj_done_out(obj_done_out), .tri_count_out(tri_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc++;
    #1 vert_ready_in = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t ex(input logic [3:0][31:0] v, input logic [1:0] i);
    return {v, i, i == 2'd2};
  endfunction

  function automatic logic [3:0][31:0] mk(input int x, input int y, input int z, input int w);
    return {32'(x), 32'(y), 32'(z), 32'(w)};
  endfunction

  function automatic logic [3:0][31:0] rv();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk_in) begin
    cur = {vert_out, vert_idx_out, tri_last_out};
    if (rst_in) begin
      prev_stall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", vert_valid_out ? cur : '1, held);
      if (vert_valid_out && vert_ready_in) begin
        if (hs_cnt < 512) hs_cyc[hs_cnt] = cyc;
        hs_cnt++;
        if (sb.size() == 0) chk("extra_vertex", obs_t'(sb.size()), obs_t'(1));
        else chk("vertex", cur, sb.pop_front());
      end
      prev_stall = vert_valid_out && !vert_ready_in;
      held = cur;
      if (!ready_out) saw_full = 1'b1;
      if (obj_done_out) begin
        done_cycles++;
        if (!prev_done) begin
          done_pulses++;
          done_hs = hs_cnt;
        end
      end
      prev_done = obj_done_out;
    end
  end

  task automatic send_tri(input logic [3:0][31:0] a, input logic [3:0][31:0] b,
                          input logic [3:0][31:0] c, input logic d);
    int t = 0;
    @(negedge clk_in);
    while (!ready_out && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (!ready_out) chk("accept_wait", obs_t'(ready_out), obs_t'(1));
    v1_in = a; v2_in = b; v3_in = c; valid_in = 1'b1; obj_done_in = d;
    sb.push_back(ex(a, 2'd0)); sb.push_back(ex(b, 2'd1)); sb.push_back(ex(c, 2'd2));
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    obj_done_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    chk("drain", obs_t'(sb.size()), obs_t'(0));
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    int b, dp, dc, t;
    logic [15:0] tc;
    logic [3:0][31:0] c;
    #2;
    chk("rst_ready", obs_t'(ready_out), obs_t'(0));
    chk("rst_valid", obs_t'(vert_valid_out), obs_t'(0));
    chk("rst_count", obs_t'(tri_count_out), obs_t'(0));
    chk("rst_outs", obs_t'({vert_out, vert_idx_out, tri_last_out, obj_done_out}), obs_t'(0));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("ready_after_rst", obs_t'(ready_out), obs_t'(1));
    // single triangle, full rate
    b = hs_cnt;
    send_tri(mk(1, 2, 3, 1), mk(4, 5, 6, 1), mk(7, 8, 9, 1), 1'b0);
    @(negedge clk_in);
    chk("lat_idle", obs_t'(vert_valid_out), obs_t'(0));
    @(negedge clk_in);
    chk("lat_first", obs_t'(vert_valid_out), obs_t'(1));
    drain();
    chk("t1_consec", obs_t'(hs_cyc[b+2] - hs_cyc[b]), obs_t'(2));
    chk("t1_count", obs_t'(tri_count_out), obs_t'(1));
    // four back-to-back triangles
    saw_full = 1'b0;
    b = hs_cnt;
    for (int i = 0; i < 4; i++) send_tri(rv(), rv(), rv(), 1'b0);
    drain();
    chk("t2_full_seen", obs_t'(saw_full), obs_t'(1));
    chk("t2_no_bubble", obs_t'(hs_cyc[b+11] - hs_cyc[b]), obs_t'(11));
    chk("t2_count", obs_t'(tri_count_out), obs_t'(5));
    // random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 5; i++) send_tri(rv(), rv(), rv(), 1'b0);
    drain();
    rnd_mode = 1'b0;
    chk("t3_count", obs_t'(tri_count_out), obs_t'(10));
    // object end with the last of three triangles
    b = hs_cnt; dp = done_pulses; dc = done_cycles;
    for (int i = 0; i < 3; i++) send_tri(rv(), rv(), rv(), i == 2);
    drain();
    repeat (5) @(negedge clk_in);
    chk("t4_pulses", obs_t'(done_pulses), obs_t'(dp + 1));
    chk("t4_width", obs_t'(done_cycles), obs_t'(dc + 1));
    chk("t4_after_9", obs_t'(done_hs), obs_t'(b + 9));
    chk("t4_count", obs_t'(tri_count_out), obs_t'(13));
    // full FIFO with pop and valid in the same cycle
    rdy_fix = 1'b0;
    repeat (2) @(negedge clk_in);
    send_tri(rv(), rv(), rv(), 1'b0);
    send_tri(rv(), rv(), rv(), 1'b0);
    @(negedge clk_in);
    chk("t5_full", obs_t'(ready_out), obs_t'(0));
    rdy_fix = 1'b1;
    t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (!(vert_idx_out == 2'd2 && vert_ready_in) && t < 50);
    chk("t5_pop_ready", obs_t'(ready_out), obs_t'(0));
    c = rv();
    v1_in = c; v2_in = c; v3_in = c; valid_in = 1'b1;
    tc = tri_count_out;
    @(posedge clk_in);
    #1 chk("t5_no_accept", obs_t'(tri_count_out), obs_t'(tc));
    @(negedge clk_in);
    chk("t5_ready_next", obs_t'(ready_out), obs_t'(1));
    sb.push_back(ex(c, 2'd0)); sb.push_back(ex(c, 2'd1)); sb.push_back(ex(c, 2'd2));
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    chk("t5_accept", obs_t'(tri_count_out), obs_t'(tc + 16'd1));
    drain();
    // asynchronous reset while emitting idx1
    dp = done_pulses;
    rdy_fix = 1'b0;
    repeat (2) @(negedge clk_in);
    send_tri(rv(), rv(), rv(), 1'b0);
    t = 0;
    while (!vert_valid_out && t < 20) begin
      @(negedge clk_in);
      t++;
    end
    chk("t6_idx0", obs_t'({vert_valid_out, vert_idx_out}), obs_t'(3'b100));
    rdy_fix = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #3 chk("t6_idx1", obs_t'(vert_idx_out), obs_t'(1));
    rst_in = 1'b1;
    #1;
    chk("t6_rst_outs", obs_t'({vert_out, vert_idx_out, tri_last_out, vert_valid_out, obj_done_out}), obs_t'(0));
    chk("t6_rst_count", obs_t'(tri_count_out), obs_t'(0));
    chk("t6_rst_ready", obs_t'(ready_out), obs_t'(0));
    sb.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    send_tri(rv(), rv(), rv(), 1'b0);
    drain();
    chk("t6_count", obs_t'(tri_count_out), obs_t'(1));
    chk("t6_no_done", obs_t'(done_pulses), obs_t'(dp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
